// File: rtl/mod_add_seq.sv
// Word-serial command sequencer around e_mod_add: loads two operands as WW-bit
// words, fires start_add, waits for done_add and streams the sum back out.
module mod_add_seq #(
   parameter int WIDTH = 256,
   parameter int WW    = 32,
   parameter int TMO   = 1023
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             cmd_valid,
   input  logic [1:0]       cmd_sel,
   output logic             cmd_ready,
   input  logic             in_valid,
   input  logic [WW-1:0]    in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WW-1:0]    out_data,
   output logic             out_last,
   input  logic             out_ready,
   output logic             err_tmo,
   output logic [1:0]       sel,
   output logic             start_add,
   output logic [WIDTH-1:0] nu_1,
   output logic [WIDTH-1:0] nu_2,
   input  logic [WIDTH-1:0] add_nu,
   input  logic             done_add
);

   localparam int N  = WIDTH / WW;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam int TW = $clog2(TMO + 1);

   localparam logic [CW-1:0] LAST_W   = CW'(N - 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LOAD_A = 3'd1;
   localparam logic [2:0] S_LOAD_B = 3'd2;
   localparam logic [2:0] S_START  = 3'd3;
   localparam logic [2:0] S_WAIT   = 3'd4;
   localparam logic [2:0] S_UNLOAD = 3'd5;

   logic [2:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [TW-1:0]    tmo_q, tmo_d;
   logic [1:0]       sel_q, sel_d;
   logic             err_q, err_d;
   logic [WIDTH-1:0] nu1_q, nu1_d;
   logic [WIDTH-1:0] nu2_q, nu2_d;
   logic [WIDTH-1:0] res_q, res_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tmo_d   = tmo_q;
      sel_d   = sel_q;
      err_d   = err_q;
      nu1_d   = nu1_q;
      nu2_d   = nu2_q;
      res_d   = res_q;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               sel_d   = cmd_sel;
               err_d   = 1'b0;
               cnt_d   = '0;
               state_d = S_LOAD_A;
            end
         end
         S_LOAD_A: begin
            if (in_valid) begin
               nu1_d[cnt_q*WW +: WW] = in_data;
               if (cnt_q == LAST_W) begin
                  cnt_d   = '0;
                  state_d = S_LOAD_B;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         S_LOAD_B: begin
            if (in_valid) begin
               nu2_d[cnt_q*WW +: WW] = in_data;
               if (cnt_q == LAST_W) begin
                  cnt_d   = '0;
                  state_d = S_START;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         S_START: begin
            tmo_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            tmo_d = tmo_q + 1'b1;
            // A done_add arriving on the timeout cycle still delivers its result.
            if (done_add) begin
               res_d   = add_nu;
               cnt_d   = '0;
               state_d = S_UNLOAD;
            end else if (tmo_q == TMO_LAST) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_UNLOAD: begin
            if (out_ready) begin
               if (cnt_q == LAST_W) begin
                  cnt_d   = '0;
                  state_d = S_IDLE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         tmo_q   <= '0;
         sel_q   <= '0;
         err_q   <= 1'b0;
         nu1_q   <= '0;
         nu2_q   <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tmo_q   <= tmo_d;
         sel_q   <= sel_d;
         err_q   <= err_d;
         nu1_q   <= nu1_d;
         nu2_q   <= nu2_d;
         res_q   <= res_d;
      end
   end

   // Every output is a decode of registered state, never of an input.
   assign cmd_ready = (state_q == S_IDLE);
   assign in_ready  = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
   assign start_add = (state_q == S_START);
   assign out_valid = (state_q == S_UNLOAD);
   assign out_data  = (state_q == S_UNLOAD) ? res_q[cnt_q*WW +: WW] : '0;
   assign out_last  = (state_q == S_UNLOAD) && (cnt_q == LAST_W);
   assign err_tmo   = err_q;
   assign sel       = sel_q;
   assign nu_1      = nu1_q;
   assign nu_2      = nu2_q;

endmodule

// File: tb/tb_mod_add_seq.sv
// Scoreboard bench for mod_add_seq with a behavioural e_mod_add stub.
module tb_mod_add_seq;
   localparam int WIDTH = 256;
   localparam int WW    = 32;
   localparam int TMO   = 16;
   localparam int N     = WIDTH / WW;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             cmd_valid = 1'b0;
   logic [1:0]       cmd_sel = '0;
   logic             cmd_ready;
   logic             in_valid = 1'b0;
   logic [WW-1:0]    in_data = '0;
   logic             in_ready;
   logic             out_valid;
   logic [WW-1:0]    out_data;
   logic             out_last;
   logic             out_ready;
   logic             err_tmo;
   logic [1:0]       sel;
   logic             start_add;
   logic [WIDTH-1:0] nu_1, nu_2, add_nu;
   logic             done_add;

   always #5 clk = ~clk;

   mod_add_seq #(.WIDTH(WIDTH), .WW(WW), .TMO(TMO)) dut (
      .clk(clk), .reset_n(reset_n),
      .cmd_valid(cmd_valid), .cmd_sel(cmd_sel), .cmd_ready(cmd_ready),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
      .err_tmo(err_tmo), .sel(sel), .start_add(start_add),
      .nu_1(nu_1), .nu_2(nu_2), .add_nu(add_nu), .done_add(done_add)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   logic [1:0]       exp_sel;
   logic [WIDTH-1:0] exp_a, exp_b;
   int               n_acc = 0;
   int               n_start = 0;
   int               n_pop = 0;
   int               rdy_pct = 100;
   int               gap_pct = 0;
   int               lat = 5;
   bit               hang = 1'b0;
   bit               inj_start = 1'b0;
   logic             inj_b = 1'b0;
   logic             inj_s;
   logic [WW:0]      sb[$];

   // e_mod_add stub: sum of the presented buses, done after lat cycles.
   logic             stub_done;
   logic [WIDTH-1:0] stub_sum;
   int               stub_wait;
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stub_done <= 1'b0;
         stub_wait <= 0;
         stub_sum  <= '0;
      end else begin
         stub_done <= 1'b0;
         if (start_add) begin
            stub_sum  <= nu_1 + nu_2;
            stub_wait <= hang ? 0 : lat;
         end else if (stub_wait > 0) begin
            stub_wait <= stub_wait - 1;
            if (stub_wait == 1) stub_done <= 1'b1;
         end
      end
   end
   assign add_nu   = stub_sum;
   assign done_add = stub_done | inj_b | inj_s;

   // Output monitor, out_ready driver and start_add checker.
   initial begin
      logic [WW-1:0] pd;
      logic          pl;
      logic [WW:0]   e;
      bit            ps;
      ps = 1'b0;
      out_ready = 1'b0;
      inj_s = 1'b0;
      forever begin
         @(negedge clk);
         inj_s = 1'b0;
         if (!reset_n) begin
            ps = 1'b0;
            out_ready = 1'b0;
         end else begin
            if (start_add) begin
               check("start_after_acc", n_acc, 2 * N);
               check("start_sel", sel, exp_sel);
               check("start_nu_1", nu_1, exp_a);
               check("start_nu_2", nu_2, exp_b);
               n_start++;
               if (inj_start) inj_s = 1'b1;
            end
            if (ps) begin
               check("hold_valid", out_valid, 1);
               check("hold_data", out_data, pd);
               check("hold_last", out_last, pl);
            end
            out_ready = ($urandom_range(99) < rdy_pct);
            ps = 1'b0;
            if (out_valid) begin
               if (out_ready) begin
                  if (sb.size() == 0) begin
                     check("extra_word", out_valid, 0);
                  end else begin
                     e = sb.pop_front();
                     check("word", out_data, e[WW-1:0]);
                     check("last", out_last, e[WW]);
                     n_pop++;
                  end
               end else begin
                  ps = 1'b1;
                  pd = out_data;
                  pl = out_last;
               end
            end
         end
      end
   end

   task automatic push_result(input logic [WIDTH-1:0] r);
      for (int k = 0; k < N; k++) begin
         logic l;
         l = (k == N - 1);
         sb.push_back({l, r[k*WW +: WW]});
      end
   endtask

   task automatic send_cmd(input logic [1:0] s, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      int t;
      t = 0;
      exp_sel = s;
      exp_a = a;
      exp_b = b;
      n_acc = 0;
      @(negedge clk);
      while (!cmd_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      check("cmd_ready", cmd_ready, 1);
      cmd_valid = 1'b1;
      cmd_sel = s;
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_sel = '0;
   endtask

   task automatic load_words(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit inj_en);
      for (int k = 0; k < 2 * N; k++) begin
         logic [WW-1:0] w;
         int t;
         t = 0;
         w = (k < N) ? a[k*WW +: WW] : b[(k-N)*WW +: WW];
         while ($urandom_range(99) < gap_pct) begin
            in_valid = 1'b0;
            @(negedge clk);
         end
         in_valid = 1'b1;
         in_data = w;
         if (inj_en && k == N + 1) inj_b = 1'b1;
         while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
         end
         if (t == 50) check("in_ready_wait", in_ready, 1);
         n_acc++;
         @(negedge clk);
         in_valid = 1'b0;
         inj_b = 1'b0;
      end
   endtask

   task automatic wait_start();
      int t;
      t = 0;
      while (!start_add && t < 20) begin
         @(negedge clk);
         t++;
      end
      check("start_seen", start_add, 1);
   endtask

   task automatic finish_op(input int s0);
      int t;
      t = 0;
      while (sb.size() != 0 && t < 2000) begin
         @(negedge clk);
         #1;
         t++;
      end
      check("drained", sb.size(), 0);
      @(negedge clk);
      check("idle_after", cmd_ready, 1);
      check("idle_out_valid", out_valid, 0);
      check("one_start", n_start - s0, 1);
   endtask

   task automatic run_op(input logic [1:0] s, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input bit inj_en);
      int s0;
      s0 = n_start;
      push_result(a + b);
      send_cmd(s, a, b);
      load_words(a, b, inj_en);
      finish_op(s0);
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_cmd_ready"}, cmd_ready, 1);
      check({tag, "_in_ready"}, in_ready, 0);
      check({tag, "_out_valid"}, out_valid, 0);
      check({tag, "_out_data"}, out_data, 0);
      check({tag, "_out_last"}, out_last, 0);
      check({tag, "_err_tmo"}, err_tmo, 0);
      check({tag, "_sel"}, sel, 0);
      check({tag, "_start_add"}, start_add, 0);
      check({tag, "_nu_1"}, nu_1, 0);
      check({tag, "_nu_2"}, nu_2, 0);
   endtask

   task automatic release_reset();
      @(negedge clk);
      #2 reset_n = 1'b1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      logic [WIDTH-1:0] a, b;
      int t;
      repeat (3) @(negedge clk);
      check_reset("rst0");
      release_reset();

      // Basic operation: 1 + 2 with sel 2.
      run_op(2'd2, 256'd1, 256'd2, 1'b0);

      // Byte-ramp result with random output backpressure.
      a = '0;
      for (int i = 0; i < 32; i++) a[i*8 +: 8] = 8'(i + 1);
      rdy_pct = 50;
      run_op(2'd1, a, '0, 1'b0);

      // Input gaps, word k carries k + 0x100.
      gap_pct = 40;
      rdy_pct = 70;
      for (int k = 0; k < N; k++) begin
         a[k*WW +: WW] = 32'(k + 256);
         b[k*WW +: WW] = 32'(k + N + 256);
      end
      run_op(2'd3, a, b, 1'b0);
      gap_pct = 0;
      rdy_pct = 100;

      // Timeout: stub never answers.
      hang = 1'b1;
      a = {8{$urandom}};
      b = {8{$urandom}};
      send_cmd(2'd0, a, b);
      load_words(a, b, 1'b0);
      wait_start();
      repeat (16) @(negedge clk);
      check("tmo_early_err", err_tmo, 0);
      check("tmo_early_busy", cmd_ready, 0);
      @(negedge clk);
      check("tmo_err", err_tmo, 1);
      check("tmo_idle", cmd_ready, 1);
      check("tmo_no_out", out_valid, 0);
      hang = 1'b0;

      // Stray done_add in LOAD_B and in START must be ignored; err_tmo clears.
      inj_start = 1'b1;
      push_result(256'd12);
      t = n_start;
      send_cmd(2'd1, 256'd5, 256'd7);
      check("err_cleared", err_tmo, 0);
      load_words(256'd5, 256'd7, 1'b1);
      finish_op(t);
      inj_start = 1'b0;

      // Reset while waiting for the core.
      lat = 12;
      a = {8{$urandom}};
      b = {8{$urandom}};
      send_cmd(2'd2, a, b);
      load_words(a, b, 1'b0);
      wait_start();
      repeat (3) @(negedge clk);
      #2 reset_n = 1'b0;
      #1 check_reset("rst_wait");
      sb.delete();
      release_reset();

      // Reset in the middle of the result stream.
      lat = 3;
      rdy_pct = 50;
      push_result(a + b);
      t = n_pop;
      send_cmd(2'd3, a, b);
      load_words(a, b, 1'b0);
      while (n_pop < t + 3) begin
         @(negedge clk);
         #1;
      end
      #2 reset_n = 1'b0;
      #1 check_reset("rst_unload");
      sb.delete();
      release_reset();

      // Fresh command after reset behaves like the first one.
      rdy_pct = 100;
      lat = 5;
      run_op(2'd2, 256'd1, 256'd2, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
